// File: rtl/icache_pkg.sv
// Shared types and address-split width helpers for the instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fillState_t;

  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned BYTE_OFF_BITS = 2;

  function automatic int unsigned offsetBits(input int unsigned wordsPerLine);
    return unsigned'($clog2(wordsPerLine));
  endfunction

  function automatic int unsigned indexBits(input int unsigned lineCount);
    return unsigned'($clog2(lineCount));
  endfunction

  function automatic int unsigned tagBits(input int unsigned bitCount,
                                          input int unsigned lineCount,
                                          input int unsigned wordsPerLine);
    return bitCount - BYTE_OFF_BITS - offsetBits(wordsPerLine) - indexBits(lineCount);
  endfunction

  // Zero-width fields (one word per line) still need a 1-bit carrier.
  function automatic int unsigned safeWidth(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: state, word counter, latched line address, pending
// flush and the request/valid handshake to the backing store.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int unsigned BIT_COUNT      = 32,
  parameter int unsigned LINE_COUNT     = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned IDX_W  = indexBits(LINE_COUNT),
  localparam int unsigned WORD_W = safeWidth(offsetBits(WORDS_PER_LINE))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookupHit,
  input  logic [BIT_COUNT-1:0] lineBase,
  input  logic [IDX_W-1:0]     lineIndex,
  input  logic                 Flush,
  input  logic                 MemValid,
  output logic                 isIdle_c,
  output logic                 startFill_c,
  output logic                 wordWe_c,
  output logic                 fillDone_c,
  output logic                 clearAll_c,
  output logic [WORD_W-1:0]    wordIdx,
  output logic [IDX_W-1:0]     fillIndex,
  output logic [BIT_COUNT-1:0] fillBase,
  output logic                 MemReq,
  output logic [BIT_COUNT-1:0] MemAdr
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  fillState_t           state;
  fillState_t           nextState;
  logic [WORD_W-1:0]    cntQ;
  logic [IDX_W-1:0]     idxQ;
  logic [BIT_COUNT-1:0] baseQ;
  logic                 pendQ;

  assign isIdle_c  = (state == IDLE);
  assign wordIdx   = cntQ;
  assign fillIndex = idxQ;
  assign fillBase  = baseQ;

  // Next state and per-cycle array strobes.
  always_comb begin
    nextState   = state;
    startFill_c = 1'b0;
    wordWe_c    = 1'b0;
    fillDone_c  = 1'b0;
    clearAll_c  = 1'b0;
    case (state)
      IDLE: begin
        clearAll_c = Flush;
        if (!lookupHit) begin
          startFill_c = 1'b1;
          nextState   = FILL;
        end
      end
      FILL: begin
        if (MemValid) begin
          wordWe_c = 1'b1;
          if (cntQ == LAST_WORD) begin
            fillDone_c = 1'b1;
            clearAll_c = pendQ | Flush;
            nextState  = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Later assignments take priority: fill completion overrides the step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cntQ   <= '0;
      idxQ   <= '0;
      baseQ  <= '0;
      pendQ  <= 1'b0;
      MemReq <= 1'b0;
      MemAdr <= '0;
    end else begin
      state <= nextState;
      if (startFill_c) begin
        baseQ  <= lineBase;
        idxQ   <= lineIndex;
        cntQ   <= '0;
        pendQ  <= 1'b0;
        MemReq <= 1'b1;
        MemAdr <= lineBase;
      end
      if ((state == FILL) && Flush) begin
        pendQ <= 1'b1;
      end
      if (wordWe_c) begin
        cntQ   <= cntQ + WORD_W'(1);
        MemAdr <= MemAdr + BIT_COUNT'(4);
      end
      if (fillDone_c) begin
        cntQ   <= '0;
        pendQ  <= 1'b0;
        MemReq <= 1'b0;
        MemAdr <= '0;
      end
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with multi-cycle refill and flush.
// Optional hit/miss counters under ICACHE_PERF_COUNTERS_EN.
module instr_cache
  import icache_pkg::*;
#(
  parameter int unsigned BIT_COUNT      = 32,
  parameter int unsigned LINE_COUNT     = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_COUNT-1:0] PC,
  output logic [31:0]          Instr,
  output logic                 FetchStall,
  input  logic                 Flush,
  output logic                 MemReq,
  output logic [BIT_COUNT-1:0] MemAdr,
  input  logic                 MemValid,
  input  logic [31:0]          MemData
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]          HitCount,
  output logic [31:0]          MissCount
`endif
);

  localparam int unsigned OFF_BITS = offsetBits(WORDS_PER_LINE);
  localparam int unsigned IDX_W    = indexBits(LINE_COUNT);
  localparam int unsigned WORD_W   = safeWidth(OFF_BITS);
  localparam int unsigned TAG_W    = tagBits(BIT_COUNT, LINE_COUNT, WORDS_PER_LINE);
  localparam int unsigned IDX_LSB  = BYTE_OFF_BITS + OFF_BITS;
  localparam int unsigned TAG_LSB  = IDX_LSB + IDX_W;
  localparam logic [BIT_COUNT-1:0] LINE_MASK = BIT_COUNT'(WORDS_PER_LINE * 4 - 1);
  localparam logic [BIT_COUNT-1:0] WORD_MASK = BIT_COUNT'(WORDS_PER_LINE - 1);

  logic [WORD_BITS-1:0] dataMem [LINE_COUNT][WORDS_PER_LINE];
  logic [TAG_W-1:0]     tagMem  [LINE_COUNT];
  logic [LINE_COUNT-1:0] validBits;

  logic [IDX_W-1:0]     pcIndex;
  logic [WORD_W-1:0]    pcWord;
  logic [TAG_W-1:0]     pcTag;
  logic [BIT_COUNT-1:0] pcBase;
  logic                 lookupHit;
  logic                 hit;

  logic                 isIdle;
  logic                 startFill;
  logic                 wordWe;
  logic                 fillDone;
  logic                 clearAll;
  logic [WORD_W-1:0]    wordIdx;
  logic [IDX_W-1:0]     fillIndex;
  logic [BIT_COUNT-1:0] fillBase;

  assign pcIndex = IDX_W'(PC >> IDX_LSB);
  assign pcWord  = WORD_W'((PC >> BYTE_OFF_BITS) & WORD_MASK);
  assign pcTag   = TAG_W'(PC >> TAG_LSB);
  assign pcBase  = PC & ~LINE_MASK;

  // Combinational lookup; a line under refill never hits because the FSM is busy.
  assign lookupHit  = validBits[pcIndex] && (tagMem[pcIndex] == pcTag);
  assign hit        = isIdle && lookupHit;
  assign FetchStall = ~hit;
  assign Instr      = hit ? dataMem[pcIndex][pcWord] : 32'd0;

  icache_refill_fsm #(
    .BIT_COUNT     (BIT_COUNT),
    .LINE_COUNT    (LINE_COUNT),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_refill (
    .clk        (clk),
    .reset      (reset),
    .lookupHit  (lookupHit),
    .lineBase   (pcBase),
    .lineIndex  (pcIndex),
    .Flush      (Flush),
    .MemValid   (MemValid),
    .isIdle_c   (isIdle),
    .startFill_c(startFill),
    .wordWe_c   (wordWe),
    .fillDone_c (fillDone),
    .clearAll_c (clearAll),
    .wordIdx    (wordIdx),
    .fillIndex  (fillIndex),
    .fillBase   (fillBase),
    .MemReq     (MemReq),
    .MemAdr     (MemAdr)
  );

  always_ff @(posedge clk) begin
    if (wordWe) begin
      dataMem[fillIndex][wordIdx] <= MemData;
    end
    if (fillDone) begin
      tagMem[fillIndex] <= TAG_W'(fillBase >> TAG_LSB);
    end
  end

  // A line is dropped as soon as its refill starts so a partial fill never hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      validBits <= '0;
    end else if (clearAll) begin
      validBits <= '0;
    end else if (fillDone) begin
      validBits[fillIndex] <= 1'b1;
    end else if (startFill) begin
      validBits[pcIndex] <= 1'b0;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (hit && (HitCount != '1)) begin
        HitCount <= HitCount + 32'd1;
      end
      if (startFill && (MissCount != '1)) begin
        MissCount <= MissCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed vector table, reset/flush
// corner sequences and random fetches against a line-level cache model.
module tb_instr_cache;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        FetchStall;
  logic        Flush;
  logic        MemReq;
  logic [31:0] MemAdr;
  logic        MemValid;
  logic [31:0] MemData;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  instr_cache dut (
    .clk       (clk),
    .reset     (reset),
    .PC        (PC),
    .Instr     (Instr),
    .FetchStall(FetchStall),
    .Flush     (Flush),
    .MemReq    (MemReq),
    .MemAdr    (MemAdr),
    .MemValid  (MemValid),
    .MemData   (MemData)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .HitCount  (HitCount),
    .MissCount (MissCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Backing store contents: a fixed function of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: answers after memLat cycles per word, optional noise in idle.
  int          memLat = 1;
  bit          noiseEn = 0;
  int          waitCnt = 0;
  logic [31:0] reqAdr;
  logic [31:0] adrLog[$];

  always @(negedge clk) begin
    if (reset) begin
      MemValid = 1'b0;
      waitCnt  = 0;
    end else if (MemReq) begin
      if (waitCnt == 0) reqAdr = MemAdr;
      else chk("adr-stable", MemAdr, reqAdr);
      if (waitCnt + 1 >= memLat) begin
        MemValid = 1'b1;
        MemData  = memWord(MemAdr);
        adrLog.push_back(MemAdr);
        waitCnt  = 0;
      end else begin
        MemValid = 1'b0;
        waitCnt++;
      end
    end else begin
      MemValid = noiseEn && ($urandom_range(0, 3) == 0);
      MemData  = $urandom;
      waitCnt  = 0;
    end
  end

  // Line-level reference model: 16 lines of 4 words, tag = PC[31:8], index = PC[7:4].
  bit          mValid[16];
  logic [23:0] mTag[16];

  function automatic int modelStall(input logic [31:0] pc, input int lat, input int mode);
    int idx;
    idx = int'(pc[7:4]);
    if (mValid[idx] && mTag[idx] == pc[31:8]) return 0;
    return ((mode == 3) ? 2 : 1) * (1 + 4 * lat);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endtask

  // mode: 0 plain, 1 flush on hit cycle, 2 flush on first cycle, 3 flush during fill
  task automatic doFetch(input logic [31:0] pc, input int lat, input int mode,
                         input int expStall, input string nm);
    int stall;
    int fills;
    int idx;
    bit flushed;
    logic [31:0] base;
    base    = {pc[31:4], 4'h0};
    idx     = int'(pc[7:4]);
    fills   = (expStall == 0) ? 0 : ((mode == 3) ? 2 : 1);
    memLat  = lat;
    adrLog.delete();
    PC      = pc;
    Flush   = (mode == 2);
    stall   = 0;
    flushed = 0;
    #1;
    while (FetchStall && stall < 300) begin
      stall++;
      @(posedge clk);
      #1;
      Flush = 1'b0;
      if (mode == 3 && !flushed && adrLog.size() == 1) begin
        Flush   = 1'b1;
        flushed = 1;
      end
      #1;
    end
    chk({nm, " stall"}, stall, expStall);
    chk({nm, " instr"}, Instr, memWord({pc[31:2], 2'b00}));
    chk({nm, " memreq"}, {31'd0, MemReq}, 32'd0);
    chk({nm, " nreq"}, adrLog.size(), 4 * fills);
    for (int i = 0; i < adrLog.size() && i < 4 * fills; i++)
      chk({nm, " memadr"}, adrLog[i], base + 32'(4 * (i % 4)));
    if (mode != 0 && !(mode == 3 && fills == 0)) clearModel();
    if (fills > 0 && mode != 1) begin
      mValid[idx] = 1'b1;
      mTag[idx]   = pc[31:8];
    end
    if (mode == 1) Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          mode;
    int          expStall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    vec_t v;
    reset    = 1'b1;
    PC       = 32'h40;
    Flush    = 1'b0;
    MemValid = 1'b0;
    MemData  = 32'd0;
    clearModel();

    repeat (2) @(posedge clk);
    #1;
    chk("rst memreq", {31'd0, MemReq}, 32'd0);
    chk("rst memadr", MemAdr, 32'd0);
    chk("rst instr", Instr, 32'd0);
    chk("rst stall", {31'd0, FetchStall}, 32'd1);
    reset = 1'b0;

    vecs.push_back('{32'h040, 1, 0, 5});   // cold miss
    vecs.push_back('{32'h044, 1, 0, 0});   // sequential hits
    vecs.push_back('{32'h048, 1, 0, 0});
    vecs.push_back('{32'h04C, 1, 0, 0});
    vecs.push_back('{32'h140, 1, 0, 5});   // conflict eviction
    vecs.push_back('{32'h040, 1, 0, 5});
    vecs.push_back('{32'h080, 3, 0, 13});  // 3-cycle memory
    vecs.push_back('{32'h08C, 3, 0, 0});
    vecs.push_back('{32'h100, 1, 3, 10});  // flush on second word: refill twice
    vecs.push_back('{32'h040, 1, 0, 5});
    vecs.push_back('{32'h104, 1, 0, 0});
    vecs.push_back('{32'h104, 1, 1, 0});   // flush in idle after hit
    vecs.push_back('{32'h108, 2, 0, 9});
    vecs.push_back('{32'h200, 1, 2, 5});   // flush together with a miss
    vecs.push_back('{32'h044, 1, 0, 5});
    vecs.push_back('{32'h204, 1, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      doFetch(v.pc, v.lat, v.mode, v.expStall, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a refill.
    PC     = 32'h300;
    memLat = 1;
    adrLog.delete();
    n = 0;
    while (adrLog.size() < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midfill reached", {31'd0, n < 50}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midfill memreq", {31'd0, MemReq}, 32'd0);
    chk("midfill stall", {31'd0, FetchStall}, 32'd1);
    reset = 1'b0;
    clearModel();
    doFetch(32'h300, 1, 0, 5, "after-reset");

    // Random fetches against the model, with idle-time MemValid noise.
    noiseEn = 1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] pc;
      int lat;
      int r;
      int mode;
      pc   = 32'($urandom_range(0, 511)) << 2;
      lat  = $urandom_range(1, 3);
      r    = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : r - 6;
      doFetch(pc, lat, mode, modelStall(pc, lat, mode), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache that sits between the compute core's fetch port (`PC`/`Instr`) and a backing instruction store with a variable-latency request/valid handshake. It is the successor to the fixed zero-latency instruction memory hookup. It is generalised in address width, line count and line size, and adds a multi-cycle refill state machine, a fetch stall to the core, and a whole-cache flush.

## Interface
- `BIT_COUNT`, 32, address width in bits.
- `LINE_COUNT`, 16, number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, ≥1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PC`  in  BIT_COUNT  fetch byte address from the core; bits [1:0] ignored.
- `Instr`  out  32  fetched instruction; meaningful only when `FetchStall`=0.
- `FetchStall`  out  1  high while the addressed word is not available this cycle.
- `Flush`  in  1  single-cycle pulse that invalidates every line.
- `MemReq`  out  1  refill word request to the backing store.
- `MemAdr`  out  BIT_COUNT  word-aligned byte address of the requested word.
- `MemValid`  in  1  backing store returns `MemData` for the current request.
- `MemData`  in  32  refill data.

## Operation
- Address split, LSB to MSB: 2 byte bits, log2(WORDS_PER_LINE) word-offset bits, log2(LINE_COUNT) index bits, remaining tag bits.
- Per line: valid bit, tag, WORDS_PER_LINE data words.
- Lookup is combinational. A hit requires valid=1, tag match and state IDLE. On a hit, `Instr` is the selected word and `FetchStall`=0 in the same cycle.
- FSM states:
  - IDLE: on a miss, latch the line base address (PC with word-offset and byte bits zeroed) and the index, clear the word counter, and go to FILL. `FetchStall`=1.
  - FILL: `MemReq`=1 and `MemAdr` = base + 4×counter. `MemAdr` is held stable until `MemValid`. When `MemValid`=1, write `MemData` into word[counter] and increment the counter. After the last word, write the tag, set valid, and go to IDLE.
- `FetchStall`=1 in every FILL cycle, and in IDLE whenever the lookup misses.
- `PC` is not re-sampled during FILL; the latched address is used. After returning to IDLE the lookup re-evaluates the current `PC`.
- `Flush`:
  - In IDLE, all valid bits clear at the next edge.
  - In FILL, the flush is recorded as pending. The fill completes, the line is written, and then all valid bits, including the new line, clear on the cycle of the return to IDLE.
- `MemValid` while in IDLE is ignored.

## Timing
- Reset values: state IDLE, all valid bits 0, counter 0, `MemReq`=0, `MemAdr`=0, `Instr`=0 (data array contents irrelevant), `FetchStall`=1 if `PC` is presented.
- Hit latency: 0 cycles (combinational).
- Miss penalty: 1 + Σ(per-word memory latency) cycles. With `MemValid` returned in the same cycle as `MemReq`, the penalty is WORDS_PER_LINE+1 stall cycles. The hit occurs in cycle WORDS_PER_LINE+1 after the miss.
- Handshake: one request outstanding at a time. `MemReq` may stay high across consecutive words with a new `MemAdr` on the cycle after each `MemValid`. `MemReq` drops in the cycle after the last `MemValid`.
- Reset mid-FILL: the fill is abandoned, `MemReq`=0 at the next edge, the partially written line stays invalid, and any pending flush is discarded.
- `Flush` and a miss in the same IDLE cycle: the flush applies and the FSM still enters FILL for the missing line.

## Configuration
- `ICACHE_PERF_COUNTERS_EN`: when defined, two 32-bit saturating counters are compiled in, plus output ports `HitCount` and `MissCount`.
  - `HitCount` increments once per IDLE hit cycle.
  - `MissCount` increments once per IDLE→FILL transition.
  - Both counters reset to 0. A flush does not clear them.
- When undefined, the counters and both ports are absent and there is no other behavioural difference.

## Structure
- Shared package `icache_pkg`: state enum (IDLE, FILL) and width-derivation constants/functions (offset, index and tag widths from the parameters).
- One sub-module, `icache_refill_fsm`: owns the state, word counter, latched base address/index, the pending-flush flag and the memory handshake. The top level holds the arrays and the lookup.

## Test plan
- Cold miss: after reset, PC=0x40 with 1-cycle memory. `MemAdr` steps 0x40, 0x44, 0x48, 0x4C. `FetchStall`=1 for 5 cycles, then `Instr` = the word at 0x40.
- Sequential hits: after the fill, PC=0x44, 0x48, 0x4C. `FetchStall`=0 with the correct data each cycle and `MemReq`=0.
- Conflict eviction: with LINE_COUNT=16 and WORDS_PER_LINE=4, PC=0x40 and then PC=0x140 (same index). PC=0x140 triggers a refill. Returning to 0x40 misses again.
- Variable latency: `MemValid` delayed 3 cycles per word. `MemAdr` stays stable while waiting, and the miss penalty is 13 cycles.
- Flush during FILL: assert `Flush` on the second word. The fill completes, then PC=0x40 misses and refills.
- Reset mid-FILL: assert `reset` after 2 words. `MemReq`=0 next cycle, and the same PC then triggers a full 4-word refill.
